// File: rtl/hamming_pkt_framer.sv
// hamming_pkt_framer: frames 11-bit payload beats into SECDED (16,11) words for FIFO_top.
// Define HAMMING_ERR_INJ_EN to add per-beat bit-flip injection on payload words.
module hamming_pkt_framer #(
  parameter int unsigned MAX_WORDS  = 64,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_prior,
  input  logic [3:0]  in_port,
  input  logic        fifo_afull,
  output logic        wr_sop,
  output logic        wr_eop,
  output logic        wr_vld,
  output logic [15:0] wr_data,
  output logic        trunc_err,
  output logic [15:0] pkt_cnt
`ifdef HAMMING_ERR_INJ_EN
  ,
  input  logic [1:0]  err_inj_mode,
  input  logic [3:0]  err_pos0,
  input  logic [3:0]  err_pos1
`endif
);

  // state | meaning
  // IDLE  | waiting for in_valid with fifo_afull low
  // SOP   | sop marker on output
  // CTRL  | control word on output, payload beats accepted
  // DATA  | payload words on output, payload beats accepted
  // EOP   | final payload word on output, eop follows
  // DROP  | truncated packet, discarding beats until in_last
  // GAP   | inter-packet idle
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SOP  = 3'd1,
    CTRL = 3'd2,
    DATA = 3'd3,
    EOP  = 3'd4,
    DROP = 3'd5,
    GAP  = 3'd6
  } state_t;

  localparam int unsigned BW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t          state_q;
  logic [BW-1:0]   beats_left_q;
  logic [GW-1:0]   gap_left_q;
  logic [2:0]      prior_q;
  logic [3:0]      port_q;
  logic            trunc_pend_q;
  logic            in_ready_q;
  logic            wr_sop_q;
  logic            wr_eop_q;
  logic            wr_vld_q;
  logic [15:0]     wr_data_q;
  logic            trunc_err_q;
  logic [15:0]     pkt_cnt_q;

  logic            accept;
  logic [15:0]     ctrl_word_d;
  logic [15:0]     payload_word_d;

  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    c       = '0;
    c[3]    = d[0];
    c[5]    = d[1];
    c[6]    = d[2];
    c[7]    = d[3];
    c[15:9] = d[10:4];
    c[1]    = ^{c[3], c[5], c[7], c[9],  c[11], c[13], c[15]};
    c[2]    = ^{c[3], c[6], c[7], c[10], c[11], c[14], c[15]};
    c[4]    = ^{c[5], c[6], c[7], c[12], c[13], c[14], c[15]};
    c[8]    = ^c[15:9];
    c[0]    = ^c[15:1];
    return c;
  endfunction

  assign accept      = in_valid & in_ready_q;
  assign ctrl_word_d = enc({4'b0000, prior_q, port_q});

`ifdef HAMMING_ERR_INJ_EN
  logic [15:0] inj_mask_d;

  // Two flips at the same position cancel, leaving a clean word.
  always_comb begin
    inj_mask_d = '0;
    case (err_inj_mode)
      2'd1:    inj_mask_d = 16'd1 << err_pos0;
      2'd2:    inj_mask_d = (16'd1 << err_pos0) ^ (16'd1 << err_pos1);
      default: inj_mask_d = '0;
    endcase
    payload_word_d = enc(in_data) ^ inj_mask_d;
  end
`else
  always_comb begin
    payload_word_d = enc(in_data);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      gap_left_q   <= '0;
      prior_q      <= '0;
      port_q       <= '0;
      trunc_pend_q <= 1'b0;
      in_ready_q   <= 1'b0;
      wr_sop_q     <= 1'b0;
      wr_eop_q     <= 1'b0;
      wr_vld_q     <= 1'b0;
      wr_data_q    <= '0;
      trunc_err_q  <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      wr_sop_q    <= 1'b0;
      wr_eop_q    <= 1'b0;
      trunc_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wr_vld_q   <= 1'b0;
          wr_data_q  <= '0;
          in_ready_q <= 1'b0;
          if (in_valid && !fifo_afull) begin
            prior_q  <= in_prior;
            port_q   <= in_port;
            wr_sop_q <= 1'b1;
            wr_vld_q <= 1'b1;
            state_q  <= SOP;
          end
        end
        SOP: begin
          wr_vld_q     <= 1'b1;
          wr_data_q    <= ctrl_word_d;
          in_ready_q   <= 1'b1;
          beats_left_q <= BW'(MAX_WORDS - 1);
          trunc_pend_q <= 1'b0;
          state_q      <= CTRL;
        end
        CTRL, DATA: begin
          if (accept) begin
            wr_vld_q  <= 1'b1;
            wr_data_q <= payload_word_d;
            state_q   <= DATA;
            // beats_left_q reaching zero marks the MAX_WORDS-th beat
            if (in_last || beats_left_q == '0) begin
              in_ready_q   <= 1'b0;
              trunc_pend_q <= ~in_last;
              state_q      <= EOP;
            end else begin
              beats_left_q <= beats_left_q - 1'b1;
            end
          end else begin
            wr_vld_q <= 1'b0;
          end
        end
        EOP: begin
          wr_vld_q    <= 1'b0;
          wr_data_q   <= '0;
          wr_eop_q    <= 1'b1;
          trunc_err_q <= trunc_pend_q;
          pkt_cnt_q   <= pkt_cnt_q + 16'd1;
          if (trunc_pend_q) begin
            in_ready_q <= 1'b1;
            state_q    <= DROP;
          end else begin
            gap_left_q <= GW'(GAP_CYCLES - 1);
            state_q    <= GAP;
          end
        end
        DROP: begin
          wr_vld_q  <= 1'b0;
          wr_data_q <= '0;
          if (accept && in_last) begin
            in_ready_q   <= 1'b0;
            trunc_pend_q <= 1'b0;
            gap_left_q   <= GW'(GAP_CYCLES - 1);
            state_q      <= GAP;
          end
        end
        GAP: begin
          wr_vld_q   <= 1'b0;
          wr_data_q  <= '0;
          in_ready_q <= 1'b0;
          if (gap_left_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_left_q <= gap_left_q - 1'b1;
          end
        end
        default: begin
          in_ready_q <= 1'b0;
          wr_vld_q   <= 1'b0;
          wr_data_q  <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_sop    = wr_sop_q;
  assign wr_eop    = wr_eop_q;
  assign wr_vld    = wr_vld_q;
  assign wr_data   = wr_data_q;
  assign trunc_err = trunc_err_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_hamming_pkt_framer.sv
// tb_hamming_pkt_framer: randomized packets against a packet-level timeline model of the framer.
// Inputs are driven and outputs compared on the falling clock edge.
module tb_hamming_pkt_framer;

  localparam int MAXW = 64;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [2:0]  in_prior = '0;
  logic [3:0]  in_port = '0;
  logic        fifo_afull = 1'b0;
  logic        wr_sop;
  logic        wr_eop;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic        trunc_err;
  logic [15:0] pkt_cnt;
`ifdef HAMMING_ERR_INJ_EN
  logic [1:0]  err_inj_mode = '0;
  logic [3:0]  err_pos0 = '0;
  logic [3:0]  err_pos1 = '0;
`endif

  hamming_pkt_framer #(.MAX_WORDS(MAXW), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_prior   (in_prior),
    .in_port    (in_port),
    .fifo_afull (fifo_afull),
    .wr_sop     (wr_sop),
    .wr_eop     (wr_eop),
    .wr_vld     (wr_vld),
    .wr_data    (wr_data),
    .trunc_err  (trunc_err),
    .pkt_cnt    (pkt_cnt)
`ifdef HAMMING_ERR_INJ_EN
    ,
    .err_inj_mode (err_inj_mode),
    .err_pos0     (err_pos0),
    .err_pos1     (err_pos1)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int idle_from = 0;

  // Expected outputs for the cycle about to be sampled.
  logic        e_rdy = 1'b0, e_sop = 1'b0, e_eop = 1'b0, e_vld = 1'b0, e_trn = 1'b0;
  logic [15:0] e_data = '0;
  logic [15:0] e_cnt = '0;

  logic [10:0] pkt_q[$];

  task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h (rdy,sop,eop,vld,trn,data,cnt)", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [36:0] obs();
    return {in_ready, wr_sop, wr_eop, wr_vld, trunc_err, wr_data, pkt_cnt};
  endfunction

  function automatic logic [36:0] exp_vec();
    return {e_rdy, e_sop, e_eop, e_vld, e_trn, e_data, e_cnt};
  endfunction

  // Generic Hamming construction: data fills non-power-of-two positions in order,
  // parity bit 2^k covers every position with bit k set, bit 0 is overall parity.
  function automatic logic [15:0] ref_enc(input logic [10:0] d);
    logic [15:0] c;
    logic        x;
    int          j;
    c = '0;
    j = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      x = 1'b0;
      for (int p = 1; p < 16; p++) if ((p & (1 << k)) != 0) x = x ^ c[p];
      c[1 << k] = x;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic sample(input string tag);
    @(negedge clk);
    cyc++;
    chk(tag, obs(), exp_vec());
    e_sop = 1'b0;
    e_eop = 1'b0;
    e_trn = 1'b0;
  endtask

  task automatic run_pkt(input logic [2:0] pr, input logic [3:0] pt, input int pre_idle,
                         input int af_hold, input int vpct, input int abort_at);
    int          n, nout, acc, d, idle_cnt;
    bit          trunc;
    logic [15:0] mask;
    n        = pkt_q.size();
    trunc    = (n > MAXW);
    nout     = trunc ? MAXW : n;
    acc      = 0;
    idle_cnt = 0;
    forever begin
      sample("idle");
      in_prior = pr;
      in_port  = pt;
      in_data  = pkt_q[0];
      in_last  = 1'b0;
      if (idle_cnt < pre_idle) begin
        in_valid   = 1'b0;
        fifo_afull = 1'($urandom_range(1));
      end else begin
        in_valid   = 1'b1;
        fifo_afull = (idle_cnt < pre_idle + af_hold);
      end
      idle_cnt++;
      if (in_valid && !fifo_afull && cyc >= idle_from) break;
    end
    e_sop  = 1'b1;
    e_vld  = 1'b1;
    e_data = '0;
    sample("sop");
    in_valid = 1'($urandom_range(1));
    in_prior = 3'($urandom);
    in_port  = 4'($urandom);
    e_vld    = 1'b1;
    e_data   = ref_enc({4'b0000, pr, pt});
    e_rdy    = 1'b1;
    while (acc < nout) begin
      sample("data");
      if (abort_at > 0 && acc == abort_at) begin
        rst_n = 1'b0;
        #1;
        e_rdy = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_vld = 1'b0; e_trn = 1'b0;
        e_data = '0;
        e_cnt  = '0;
        chk("rst_async", obs(), exp_vec());
        in_valid = 1'b0;
        sample("rst_hold");
        rst_n     = 1'b1;
        idle_from = 0;
        return;
      end
      in_valid   = ($urandom_range(99) < vpct);
      in_data    = pkt_q[acc];
      in_last    = (acc == n - 1);
      fifo_afull = 1'($urandom_range(1));
      in_prior   = 3'($urandom);
      in_port    = 4'($urandom);
      mask       = '0;
`ifdef HAMMING_ERR_INJ_EN
      err_inj_mode = 2'($urandom);
      err_pos0     = 4'($urandom);
      err_pos1     = 4'($urandom);
      if (err_inj_mode == 2'd1) mask = 16'd1 << err_pos0;
      if (err_inj_mode == 2'd2) mask = (16'd1 << err_pos0) ^ (16'd1 << err_pos1);
`endif
      if (in_valid) begin
        e_vld  = 1'b1;
        e_data = ref_enc(pkt_q[acc]) ^ mask;
        acc++;
        if (acc == nout) e_rdy = 1'b0;
      end else begin
        e_vld = 1'b0;
      end
    end
    sample("last_word");
    in_valid   = 1'b1;
    in_last    = 1'b0;
    in_data    = 11'($urandom);
    fifo_afull = 1'($urandom_range(1));
    e_vld  = 1'b0;
    e_data = '0;
    e_eop  = 1'b1;
    e_trn  = trunc;
    e_cnt  = e_cnt + 16'd1;
    e_rdy  = trunc;
    sample("eop");
    if (!trunc) begin
      idle_from  = cyc + GAP;
      in_valid   = 1'b1;
      fifo_afull = 1'b0;
      return;
    end
    d = nout;
    forever begin
      in_valid   = ($urandom_range(99) < vpct);
      in_data    = pkt_q[d];
      in_last    = (d == n - 1);
      fifo_afull = 1'($urandom_range(1));
      if (in_valid) begin
        d++;
        if (d == n) begin
          e_rdy     = 1'b0;
          idle_from = cyc + GAP + 1;
          return;
        end
      end
      sample("drop");
    end
  endtask

  task automatic fill(input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(11'($urandom));
  endtask

  initial begin
    int n;
    sample("reset");
    sample("reset");
    rst_n = 1'b1;

    pkt_q = '{11'h001, 11'h7FF, 11'h000};
    run_pkt(3'd5, 4'd9, 2, 0, 100, 0);
    chk("pkt_cnt_one", {21'd0, pkt_cnt}, 37'd1);

    fill(6);
    run_pkt(3'($urandom), 4'($urandom), 0, 0, 50, 0);

    fill(70);
    run_pkt(3'd2, 4'd7, 0, 0, 100, 0);

    fill(4);
    run_pkt(3'd1, 4'd3, 3, 5, 100, 0);

    fill(20);
    run_pkt(3'd6, 4'd12, 1, 0, 100, 10);

    for (int p = 0; p < 40; p++) begin
      n = ($urandom_range(9) == 0) ? $urandom_range(65, 75) : $urandom_range(1, 12);
      fill(n);
      run_pkt(3'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(30, 100), 0);
    end

    in_valid = 1'b0;
    for (int i = 0; i < GAP + 3; i++) begin
      sample("tail");
      in_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
